// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg: shared constants, counter-width helper and channel state enum
// for the sync_debounce input conditioner.
// Contents: CH_DEF / STAGES_DEF / DB_CNT_DEF defaults, clog2_min1(), chan_state_e.
package sync_debounce_pkg;

  localparam int unsigned CH_DEF     = 4;
  localparam int unsigned STAGES_DEF = 2;
  localparam int unsigned DB_CNT_DEF = 50000;  // 1 ms at 50 MHz

  // A debounce channel is STABLE while the synchronised input matches q,
  // and COUNTING while it differs and is being qualified.
  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } chan_state_e;

  // Counter width. It must hold the values 0 .. DB_CNT-1 and is never zero bits wide.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sync_db_chan.sv
// sync_db_chan: one channel made of a STAGES-deep synchroniser, a debounce counter,
// a registered level q and optional registered rise/fall pulses.
// Ports: ck, rst_n (async, active-low), d (raw pin), q (clean level), rise/fall (1-cycle pulses).
// Optional feature: the rise/fall flops exist only when SYNC_DEBOUNCE_EDGE_EN is defined.
module sync_db_chan
  import sync_debounce_pkg::*;
#(
  parameter int unsigned STAGES  = STAGES_DEF,
  parameter int unsigned DB_CNT  = DB_CNT_DEF,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic ck,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CW   = clog2_min1(DB_CNT);
  localparam logic [CW-1:0]   TERM = CW'(DB_CNT - 1);

  logic [STAGES-1:0] r_sync;
  logic [CW-1:0]     r_cnt;
  logic              r_q;

  logic              w_s;
  chan_state_e       w_state;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_q_nxt;

  // The first stage may go metastable. Only the last stage is used.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign w_s = r_sync[STAGES-1];

  // The state is implied by comparing s with q. A mismatch that ends before
  // terminal count drops back to STABLE, which clears the counter and rejects the glitch.
  always_comb begin
    w_state   = (w_s == r_q) ? STABLE : COUNTING;
    w_cnt_nxt = r_cnt;
    w_q_nxt   = r_q;
    unique case (w_state)
      STABLE: begin
        w_cnt_nxt = '0;
      end
      COUNTING: begin
        if (r_cnt == TERM) begin
          w_q_nxt   = w_s;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_q   <= RST_VAL;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_q   <= w_q_nxt;
    end
  end

  assign q = r_q;

`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;
  logic w_upd;

  // Pulses are written on the same edge as q, so each pulse lines up with the new level.
  assign w_upd = (w_state == COUNTING) && (r_cnt == TERM);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_upd &  w_s;
      r_fall <= w_upd & ~w_s;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: CH independent channels of synchroniser plus debounce, placed
// between the board pins and the control logic.
// Ports: ck, rst_n (async, active-low), d[CH] (raw), q[CH], rise[CH], fall[CH].
// Optional feature: SYNC_DEBOUNCE_EDGE_EN enables rise/fall. When undefined, both are tied to 0.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int unsigned CH      = CH_DEF,
  parameter int unsigned STAGES  = STAGES_DEF,
  parameter int unsigned DB_CNT  = DB_CNT_DEF,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic [CH-1:0] d,
  output logic [CH-1:0] q,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_debounce: STAGES must be >= 2");
  end
  if (DB_CNT < 1) begin : g_bad_db_cnt
    $error("sync_debounce: DB_CNT must be >= 1");
  end
  if (CH < 1) begin : g_bad_ch
    $error("sync_debounce: CH must be >= 1");
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    sync_db_chan #(
      .STAGES  (STAGES),
      .DB_CNT  (DB_CNT),
      .RST_VAL (RST_VAL)
    ) u_chan (
      .ck    (ck),
      .rst_n (rst_n),
      .d     (d[g]),
      .q     (q[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

endmodule
